// File: rtl/sum_nbit_serial.sv
// Serial add/sub: CHUNK bits per cycle with a ripple-carry register, result after WIDTH/CHUNK cycles.
// Valid/ready on both sides; the result is held in DONE indefinitely until out_ready.
module sum_nbit_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] x1,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   o,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic [WIDTH:0]   o_q, o_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   int unsigned      base;
   logic [CHUNK-1:0] a_ch, b_ch, s_ch;
   logic [CHUNK:0]   csum;
   logic             cin_msb;

   assign in_ready  = rst_n & (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign o         = o_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sub_d       = sub_q;
      carry_d     = carry_q;
      o_d         = o_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      base    = int'(cnt_q) * CHUNK;
      a_ch    = a_q[base +: CHUNK];
      b_ch    = b_q[base +: CHUNK];
      csum    = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(carry_q);
      s_ch    = csum[CHUNK-1:0];
      // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
      cin_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = x0;
               b_d     = sub ? ~x1 : x1;
               sub_d   = sub;
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[base +: CHUNK] = s_ch;
            carry_d = csum[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NCH-1)) begin
               o_d         = {csum[CHUNK] ^ sub_q, acc_d};
               ovf_d       = cin_msb ^ csum[CHUNK];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         o_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sub_q       <= sub_d;
         carry_q     <= carry_d;
         o_q         <= o_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_sum_nbit_serial.sv
// Directed and swept checks of sum_nbit_serial against a scoreboard of reference results.
module tb_sum_nbit_serial;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int NCH   = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x0;
   logic [WIDTH-1:0] x1;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   o;
   logic             ovf;

   typedef struct packed {
      logic [WIDTH:0] o;
      logic           ovf;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   sum_nbit_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x0        (x0),
      .x1        (x1),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      exp_t           e;
      logic [WIDTH:0] full;
      full  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      e.o   = full;
      if (s) e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      else   e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   // Runs one operation; all driving and sampling happens 1ns after a rising edge.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input int hold, input bit given, input logic [WIDTH:0] go, input logic ggo);
      int             n;
      exp_t           e;
      exp_t           got;
      logic [WIDTH:0] o_held;
      n = 0;
      while (!in_ready && n < 30) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_before_op", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      x0        = a;
      x1        = b;
      sub       = s;
      out_ready = (hold == 0);
      if (given) begin
         e.o   = go;
         e.ovf = ggo;
      end else begin
         e = model(a, b, s);
      end
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      x0       = WIDTH'($urandom);
      x1       = WIDTH'($urandom);
      sub      = 1'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check("latency", 32'(n), 32'(NCH));
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
         got = sb.pop_front();
         check("o", 32'(o), 32'(got.o));
         check("ovf", 32'(ovf), 32'(got.ovf));
      end
      check("in_ready_done", 32'(in_ready), 32'd0);
      if (hold > 0) begin
         o_held = o;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_o_stable", 32'(o), 32'(o_held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("consumed_out_valid", 32'(out_valid), 32'd0);
      check("consumed_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      x0        = '0;
      x1        = '0;
      sub       = 1'b0;
      out_ready = 1'b1;

      // Reset: two edges with rst_n low, then release.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_o", 32'(o), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_o", 32'(o), 32'd0);

      do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b1, 17'h10000, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 17'h08000, 1'b1);
      do_op(16'h0003, 16'h0005, 1'b1, 0, 1'b1, 17'h1FFFE, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 0, 1'b1, 17'h07FFF, 1'b1);
      do_op(16'hA5A5, 16'h1234, 1'b0, 10, 1'b0, '0, 1'b0);

      // Reset during the second RUN cycle must drop the operation.
      in_valid = 1'b1;
      x0       = 16'hFFFF;
      x1       = 16'hFFFF;
      sub      = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < NCH + 2; i++) begin
         check("midrst_no_result", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      check("midrst_idle", 32'(in_ready), 32'd1);
      do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b1, 17'h05555, 1'b0);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int s = 0; s < 2; s++)
               do_op(WIDTH'(a), WIDTH'(b), 1'(s), 0, 1'b0, '0, 1'b0);

      for (int i = 0; i < 1000; i++)
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b0, '0, 1'b0);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
